// File: rtl/tft_call_arbiter.sv
// Round-robin arbiter granting four requesters exclusive access to the TFT base
// module: one call at a time, with timeout, init gating and a one-cycle GAP.

module tft_call_lane (
  input  logic       req_i,
  input  logic [1:0] cmd_i,
  input  logic       init_ok_i,
  output logic       elig_o
);
  // Before the panel is initialised only init commands may be granted.
  assign elig_o = req_i & (init_ok_i | (cmd_i == 2'd0));
endmodule

module tft_call_arbiter #(
  parameter int              TO_W   = 24,
  parameter logic [TO_W-1:0] TO_MAX = 24'hFF_FFFF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] iReq,
  input  logic [7:0] iCmd,
  output logic [3:0] oGrant,
  output logic [3:0] oDone,
  output logic [3:0] oErr,
  output logic [2:0] oCall,
  input  logic       iCallDone,
  output logic       oInitOk
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_CALL, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   grant_q, grant_d;
  logic [NUM_LANES-1:0]   done_q, done_d;
  logic [NUM_LANES-1:0]   err_q, err_d;
  logic [2:0]             call_q, call_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [1:0]             last_q, last_d;
  logic [TO_W-1:0]        cnt_q, cnt_d;
  logic                   init_ok_q, init_ok_d;

  logic [NUM_LANES-1:0]   elig;
  logic [1:0]             pick, idx, sel_cmd;
  logic                   found;

  genvar g;
  for (g = 0; g < NUM_LANES; g++) begin : g_lane
    tft_call_lane u_lane (
      .req_i    (iReq[g]),
      .cmd_i    (iCmd[2*g +: 2]),
      .init_ok_i(init_ok_q),
      .elig_o   (elig[g])
    );
  end

  // Search begins one past the last owner; i == NUM_LANES wraps back to last.
  always_comb begin
    pick  = last_q;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      idx = last_q + 2'(i);
      if (!found && elig[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    sel_cmd = iCmd[2*pick +: 2];
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cmd_d     = cmd_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    call_d    = call_q;
    done_d    = '0;
    err_d     = '0;
    init_ok_d = init_ok_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = 4'b0001 << pick;
          cmd_d   = sel_cmd;
          last_d  = pick;
          if (sel_cmd == 2'd3) begin
            err_d   = 4'b0001 << pick;
            call_d  = '0;
            state_d = S_GAP;
          end else begin
            call_d  = 3'b001 << sel_cmd;
            cnt_d   = '0;
            state_d = S_CALL;
          end
        end
      end
      S_CALL: begin
        // Completion takes priority over a coincident timeout.
        if (iCallDone) begin
          call_d  = '0;
          done_d  = grant_q;
          if (cmd_q == 2'd0) init_ok_d = 1'b1;
          state_d = S_GAP;
        end else if (cnt_q == TO_MAX) begin
          call_d  = '0;
          err_d   = grant_q;
          state_d = S_GAP;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      call_q    <= '0;
      cmd_q     <= '0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      init_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      err_q     <= err_d;
      call_q    <= call_d;
      cmd_q     <= cmd_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      init_ok_q <= init_ok_d;
    end
  end

  assign oGrant  = grant_q;
  assign oDone   = done_q;
  assign oErr    = err_q;
  assign oCall   = call_q;
  assign oInitOk = init_ok_q;
endmodule

// File: tb/tb_tft_call_arbiter.sv
// Random transaction bench for tft_call_arbiter; expectations come from a
// transaction-level model of pending requests, round-robin order and init state.

module tb_tft_call_arbiter;
  localparam int TOM = 5;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [3:0] iReq;
  logic [7:0] iCmd;
  logic [3:0] oGrant, oDone, oErr;
  logic [2:0] oCall;
  logic       iCallDone;
  logic       oInitOk;

  tft_call_arbiter #(.TO_W(24), .TO_MAX(24'd5)) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .iReq     (iReq),
    .iCmd     (iCmd),
    .oGrant   (oGrant),
    .oDone    (oDone),
    .oErr     (oErr),
    .oCall    (oCall),
    .iCallDone(iCallDone),
    .oInitOk  (oInitOk)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: pending flags and commands per requester, last owner, init state.
  bit         pend [4];
  logic [1:0] mcmd [4];
  int         last;
  bit         init_ok;

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      iReq[i]       = pend[i];
      iCmd[2*i +: 2] = mcmd[i];
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      pend[i] = 1'b0;
      mcmd[i] = 2'd0;
    end
    last    = 3;
    init_ok = 1'b0;
  endtask

  function automatic int pick_next();
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (last + i) % 4;
      if (pend[j] && (init_ok || mcmd[j] == 2'd0)) return j;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, {4'd0, oGrant}, 8'd0);
    chk({tag, "_call"},  {5'd0, oCall},  8'd0);
    chk({tag, "_done"},  {4'd0, oDone},  8'd0);
    chk({tag, "_err"},   {4'd0, oErr},   8'd0);
    chk({tag, "_initok"}, {7'd0, oInitOk}, 8'd0);
  endtask

  initial begin
    int k, dedge, n, rst_e, r;
    bit use_done, exp_done, do_rst, aborted;
    logic [1:0] c;

    RESET = 1'b0; iReq = '0; iCmd = '0; iCallDone = 1'b0;
    step(); step();
    chk_all_zero("reset");
    RESET = 1'b1;
    model_reset();

    // First transaction: requester 1 wants clear, requester 2 wants init.
    pend[1] = 1'b1; mcmd[1] = 2'd1;
    pend[2] = 1'b1; mcmd[2] = 2'd0;

    for (int t = 0; t < 250; t++) begin
      if (t > 0) begin
        for (int i = 0; i < 4; i++) begin
          if (!pend[i] && ($urandom % 2 == 0)) begin
            r = $urandom % 8;
            pend[i] = 1'b1;
            mcmd[i] = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 6) ? 2'd2 : (r == 6) ? 2'd3 : 2'd0;
          end
        end
      end
      drive();
      k = pick_next();
      if (k < 0) begin
        step();
        chk("idle_nogrant", {4'd0, oGrant}, 8'd0);
        r = $urandom % 4;
        pend[r] = 1'b1;
        mcmd[r] = 2'd0;
        continue;
      end

      step();
      last = k;
      c = mcmd[k];
      chk("grant", {4'd0, oGrant}, 8'(4'b0001 << k));

      if (c == 2'd3) begin
        chk("rsv_call", {5'd0, oCall}, 8'd0);
        chk("rsv_err",  {4'd0, oErr},  8'(4'b0001 << k));
        chk("rsv_done", {4'd0, oDone}, 8'd0);
        pend[k] = 1'b0;
        drive();
        iCallDone = 1'($urandom % 2);
        step();
        chk("rsv_gap_end_grant", {4'd0, oGrant}, 8'd0);
        chk("rsv_gap_end_err",   {4'd0, oErr},   8'd0);
        iCallDone = 1'b0;
        continue;
      end

      chk("call", {5'd0, oCall}, 8'(3'b001 << c));
      chk("call_noflag", {4'd0, oDone | oErr}, 8'd0);

      use_done = ($urandom % 4) != 0;
      dedge    = use_done ? 1 + int'($urandom % 7) : 99;
      exp_done = dedge <= TOM + 1;
      n        = exp_done ? dedge : TOM + 1;
      do_rst   = ($urandom % 16) == 0;
      rst_e    = 1 + int'($urandom % n);
      aborted  = 1'b0;

      for (int e = 1; e <= n; e++) begin
        iCmd = 8'($urandom);
        iReq = 4'($urandom);
        if (do_rst && e == rst_e) begin
          RESET = 1'b0;
          iCallDone = 1'($urandom % 2);
          step();
          RESET = 1'b1;
          iCallDone = 1'b0;
          chk_all_zero("midcall_reset");
          model_reset();
          aborted = 1'b1;
          break;
        end
        iCallDone = (e == dedge);
        step();
        if (e < n) begin
          chk("hold_grant", {4'd0, oGrant}, 8'(4'b0001 << k));
          chk("hold_call",  {5'd0, oCall},  8'(3'b001 << c));
          chk("hold_flags", {4'd0, oDone | oErr}, 8'd0);
        end else begin
          chk("end_call",  {5'd0, oCall},  8'd0);
          chk("end_grant", {4'd0, oGrant}, 8'(4'b0001 << k));
          if (exp_done) begin
            chk("end_done", {4'd0, oDone}, 8'(4'b0001 << k));
            chk("end_err",  {4'd0, oErr},  8'd0);
            if (c == 2'd0) init_ok = 1'b1;
          end else begin
            chk("to_done", {4'd0, oDone}, 8'd0);
            chk("to_err",  {4'd0, oErr},  8'(4'b0001 << k));
          end
          chk("initok", {7'd0, oInitOk}, {7'd0, init_ok});
        end
      end

      iCallDone = 1'b0;
      if (aborted) continue;
      pend[k] = 1'b0;
      drive();
      iCallDone = 1'($urandom % 2);
      step();
      chk("gap_end", {4'd0, oGrant, oDone | oErr}, 8'd0);
      chk("gap_end_call", {5'd0, oCall}, 8'd0);
      iCallDone = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
